// File: rtl/bcd_operand_sequencer.sv
// BCD operand sequencer: collects two signed 2-digit BCD operands from a keypad
// and presents them to an ALU with load strobes, opcode and compute enable.
module bcd_operand_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       neg_key,
    input  logic       add_key,
    input  logic       sub_key,
    input  logic       eq_key,
    input  logic       clr_key,
    output logic [8:0] op,
    output logic       assign_op1,
    output logic       assign_op2,
    output logic [2:0] opcode,
    output logic       alu_en,
    output logic [8:0] disp,
    output logic       busy
);

    localparam int unsigned VAL_W   = 9;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [OPC_W-1:0]   OPC_ADD    = 3'b000;
    localparam logic [OPC_W-1:0]   OPC_SUB    = 3'b010;
    localparam logic [CNT_W-1:0]   MAX_DIGITS = 2'd2;
    localparam logic [DIGIT_W-1:0] MAX_BCD    = 4'd9;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_HOLD_A  = 3'd2,
        ST_ENTER_B = 3'd3,
        ST_LOAD_B  = 3'd4,
        ST_HOLD_B  = 3'd5,
        ST_EXEC    = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   entry_q, entry_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;

    // Resolved key actions: at most one is set per cycle
    logic act_clr, act_eq, act_add, act_sub, act_neg, act_digit;
    logic digit_ok;

    // Pick the single highest-priority key that is meaningful in the current state
    always_comb begin
        act_clr   = 1'b0;
        act_eq    = 1'b0;
        act_add   = 1'b0;
        act_sub   = 1'b0;
        act_neg   = 1'b0;
        act_digit = 1'b0;
        digit_ok  = digit_valid && (digit <= MAX_BCD) && (count_q < MAX_DIGITS);
        if (clr_key) begin
            act_clr = 1'b1;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (add_key)       act_add   = 1'b1;
                    else if (sub_key)  act_sub   = 1'b1;
                    else if (neg_key)  act_neg   = 1'b1;
                    else if (digit_ok) act_digit = 1'b1;
                end
                ST_ENTER_B: begin
                    if (eq_key)        act_eq    = 1'b1;
                    else if (neg_key)  act_neg   = 1'b1;
                    else if (digit_ok) act_digit = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_ENTER_A;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (act_clr) begin
            state_d = ST_ENTER_A;
        end else begin
            case (state_q)
                ST_ENTER_A: if (act_add || act_sub) state_d = ST_LOAD_A;
                ST_LOAD_A:  state_d = ST_HOLD_A;
                ST_HOLD_A:  state_d = ST_ENTER_B;
                ST_ENTER_B: if (act_eq) state_d = ST_LOAD_B;
                ST_LOAD_B:  state_d = ST_HOLD_B;
                ST_HOLD_B:  state_d = ST_EXEC;
                ST_EXEC:    state_d = ST_DONE;
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_ENTER_A;
            endcase
        end
    end

    // Entry shift register, digit count and opcode latch
    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        opcode_d = opcode_q;
        if (act_clr) begin
            entry_d  = '0;
            count_d  = '0;
            opcode_d = OPC_ADD;
        end else if (state_q == ST_HOLD_A) begin
            // Operand A has been handed off; start a fresh entry for B
            entry_d = '0;
            count_d = '0;
        end else begin
            if (act_add) opcode_d = OPC_ADD;
            if (act_sub) opcode_d = OPC_SUB;
            if (act_neg) entry_d[8] = ~entry_q[8];
            if (act_digit) begin
                entry_d = {entry_q[8], entry_q[3:0], digit};
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q  <= '0;
            count_q  <= '0;
            opcode_q <= OPC_ADD;
        end else begin
            entry_q  <= entry_d;
            count_q  <= count_d;
            opcode_q <= opcode_d;
        end
    end

    // Moore output decode from registered state and data only
    always_comb begin
        op         = '0;
        assign_op1 = 1'b0;
        assign_op2 = 1'b0;
        alu_en     = 1'b0;
        busy       = 1'b0;
        disp       = entry_q;
        opcode     = opcode_q;
        case (state_q)
            ST_LOAD_A: begin
                op         = entry_q;
                assign_op1 = 1'b1;
                busy       = 1'b1;
            end
            ST_HOLD_A: begin
                op   = entry_q;
                busy = 1'b1;
            end
            ST_LOAD_B: begin
                op         = entry_q;
                assign_op2 = 1'b1;
                busy       = 1'b1;
            end
            ST_HOLD_B: begin
                op   = entry_q;
                busy = 1'b1;
            end
            ST_EXEC: begin
                alu_en = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE: begin
                alu_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bcd_operand_sequencer.sv
// Self-checking bench for bcd_operand_sequencer: expected operand loads are
// queued when keys are driven and matched against strobes as they appear.
module tb_bcd_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       neg_key = 1'b0, add_key = 1'b0, sub_key = 1'b0, eq_key = 1'b0, clr_key = 1'b0;
    logic [8:0] op;
    logic       assign_op1, assign_op2;
    logic [2:0] opcode;
    logic       alu_en;
    logic [8:0] disp;
    logic       busy;

    bcd_operand_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .neg_key     (neg_key),
        .add_key     (add_key),
        .sub_key     (sub_key),
        .eq_key      (eq_key),
        .clr_key     (clr_key),
        .op          (op),
        .assign_op1  (assign_op1),
        .assign_op2  (assign_op2),
        .opcode      (opcode),
        .alu_en      (alu_en),
        .disp        (disp),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] which;   // 2'b10 = op1 load, 2'b01 = op2 load
        logic [8:0] op;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       hold_pending = 1'b0;
    logic [8:0] hold_exp = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus; inputs change 1ns after the rising edge
    task automatic step(input logic v, input logic [3:0] d, input logic n, input logic a,
                        input logic s, input logic e, input logic c);
        digit_valid = v; digit = d;
        neg_key = n; add_key = a; sub_key = s; eq_key = e; clr_key = c;
        @(posedge clk); #1;
        digit_valid = 0; digit = 0;
        neg_key = 0; add_key = 0; sub_key = 0; eq_key = 0; clr_key = 0;
    endtask

    task automatic dig(input logic [3:0] d); step(1, d, 0, 0, 0, 0, 0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic clr();   step(0, 0, 0, 0, 0, 0, 1); endtask
    task automatic neg();   step(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic add();   step(0, 0, 0, 1, 0, 0, 0); endtask
    task automatic sub();   step(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic eq();    step(0, 0, 0, 0, 0, 1, 0); endtask

    // Monitor: every load strobe must match the queue head, and op must hold one more cycle
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            check("strobe_excl", 32'(assign_op1 && assign_op2), 32'd0);
            if (hold_pending) begin
                check("hold_op", 32'(op), 32'(hold_exp));
                check("hold_strobe", 32'({assign_op1, assign_op2}), 32'd0);
                hold_pending = 1'b0;
            end else if (assign_op1 || assign_op2) begin
                check("strobe_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_which", 32'({assign_op1, assign_op2}), 32'(e.which));
                    check("strobe_op", 32'(op), 32'(e.op));
                    hold_exp     = e.op;
                    hold_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset values, observed before any clock edge
        #3;
        check("rst_op", 32'(op), 32'd0);
        check("rst_strobes", 32'({assign_op1, assign_op2}), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_disp", 32'(disp), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // 42 + 17
        dig(4); dig(2);
        check("s1_disp_a", 32'(disp), 32'h042);
        sb.push_back('{which: 2'b10, op: 9'h042});
        add();
        check("s1_busy_load", 32'(busy), 32'd1);
        idle(2);
        check("s1_disp_cleared", 32'(disp), 32'd0);
        check("s1_op_idle", 32'(op), 32'd0);
        dig(1); dig(7);
        check("s1_disp_b", 32'(disp), 32'h017);
        sb.push_back('{which: 2'b01, op: 9'h017});
        eq();
        check("s1_alu_en_loadb", 32'(alu_en), 32'd0);
        idle(1);
        check("s1_alu_en_holdb", 32'(alu_en), 32'd0);
        idle(1);
        check("s1_alu_en_exec", 32'(alu_en), 32'd1);
        check("s1_busy_exec", 32'(busy), 32'd1);
        idle(1);
        check("s1_alu_en_done", 32'(alu_en), 32'd1);
        check("s1_busy_done", 32'(busy), 32'd0);
        check("s1_opcode", 32'(opcode), 32'd0);
        check("s1_sb_drained", 32'(sb.size()), 32'd0);

        // -5 - 3, with stray keys while busy and in DONE
        clr();
        check("s2_clr_alu_en", 32'(alu_en), 32'd0);
        neg(); dig(5);
        check("s2_disp_a", 32'(disp), 32'h105);
        sb.push_back('{which: 2'b10, op: 9'h105});
        sub();
        idle(1);
        add();                       // lands in HOLD_A: must be ignored
        check("s2_opcode_kept", 32'(opcode), 32'h2);
        check("s2_disp_b0", 32'(disp), 32'd0);
        dig(3);
        check("s2_disp_b", 32'(disp), 32'h003);
        sb.push_back('{which: 2'b01, op: 9'h003});
        eq();
        idle(3);
        check("s2_opcode", 32'(opcode), 32'h2);
        check("s2_alu_en_done", 32'(alu_en), 32'd1);
        dig(9); dig(8); neg(); add(); eq();
        check("s2_done_disp", 32'(disp), 32'h003);
        check("s2_done_opcode", 32'(opcode), 32'h2);
        check("s2_done_alu_en", 32'(alu_en), 32'd1);
        check("s2_sb_drained", 32'(sb.size()), 32'd0);

        // Digit count limit, invalid digits, sign toggle
        clr();
        dig(1); dig(2); dig(3);
        check("s3_third_digit", 32'(disp), 32'h012);
        dig(4'hB);
        check("s3_hex_digit", 32'(disp), 32'h012);
        clr();
        dig(7); dig(4'hA);
        check("s3_hex_ignored", 32'(disp), 32'h007);
        dig(3);
        check("s3_second_digit", 32'(disp), 32'h073);
        neg();
        check("s3_neg_on", 32'(disp), 32'h173);
        neg();
        check("s3_neg_off", 32'(disp), 32'h073);

        // Priority: add beats neg/digit; clr beats eq
        clr();
        dig(8);
        sb.push_back('{which: 2'b10, op: 9'h008});
        step(1, 4'd5, 1, 1, 0, 0, 0);
        idle(2);
        dig(6);
        step(0, 0, 0, 0, 0, 1, 1);
        check("s4_clr_disp", 32'(disp), 32'd0);
        check("s4_clr_busy", 32'(busy), 32'd0);
        check("s4_clr_opcode", 32'(opcode), 32'd0);
        idle(3);
        check("s4_no_alu_en", 32'(alu_en), 32'd0);
        check("s4_sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset during LOAD_A
        dig(5); sub();
        check("s5_in_load", 32'(assign_op1), 32'd1);
        rst = 1'b1;
        #2;
        check("s5_rst_op", 32'(op), 32'd0);
        check("s5_rst_strobe", 32'(assign_op1), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_opcode", 32'(opcode), 32'd0);
        check("s5_rst_disp", 32'(disp), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        check("s5_after_busy", 32'(busy), 32'd0);
        check("s5_after_alu_en", 32'(alu_en), 32'd0);
        check("s5_sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
